mux_8x1_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 8:1 multiplexer among 8 requesters.
//   - Grants the mux to one requester at a time and drives its select lines.
//   - Presents the selected requester's data on y, with a valid flag.
//   - Sits between the requesting sources and any single-consumer sink.

---
 rtl/mux_8x1_rr_arbiter.sv | 83 ++++++++
 tb/tb_mux_8x1_rr_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mux_8x1_rr_arbiter.sv
// mux_8x1_rr_arbiter: round-robin owner of an 8:1 mux; define ARB_HOLD_LIMIT_EN to cap tenure at MAX_HOLD cycles
module mux_8x1_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] data_in,
  output logic [7:0]          grant,
  output logic [2:0]          sel,
  output logic                valid,
  output logic [DATA_W-1:0]   y
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [2:0] ptr, w;
  logic found, take;
  if (MAX_HOLD < 2) begin : g_max_hold_check
    $error("MAX_HOLD must be >= 2");
  end
  always_comb begin
    found = 1'b0;
    w = ptr;
    for (int i = 1; i <= 8; i++) begin
      if (!found && req[3'(ptr + 3'(i))]) begin
        found = 1'b1;
        w = 3'(ptr + 3'(i));
      end
    end
  end
`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt;
  logic force_rel;
  assign force_rel = (hold_cnt == HW'(MAX_HOLD - 1)) && |(req & ~grant);
`else
  logic force_rel;
  assign force_rel = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    take = 1'b0;
    if (state == IDLE) begin
      take = found;
      state_nxt = found ? GRANT : IDLE;
    end else if (!req[sel]) begin
      take = found;
      state_nxt = found ? GRANT : IDLE;
    end else begin
      take = force_rel;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      valid <= 1'b0;
      ptr   <= 3'd7;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant <= 8'(1) << w;
        sel   <= w;
        valid <= 1'b1;
        ptr   <= w;
      end else if (state_nxt == IDLE) begin
        grant <= '0;
        valid <= 1'b0;
      end
    end
  end
`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || take)
      hold_cnt <= '0;
    else if (state == GRANT && hold_cnt != HW'(MAX_HOLD - 1))
      hold_cnt <= hold_cnt + 1'b1;
  end
`endif
  assign y = valid ? data_in[sel*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// tb_mux_8x1_rr_arbiter: directed vectors with hand-computed expectations plus random-run invariant checks
module tb_mux_8x1_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic [0:0] y;
  int n_cmp = 0;
  int n_err = 0;
  mux_8x1_rr_arbiter #(.DATA_W(1), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .grant(grant), .sel(sel), .valid(valid), .y(y)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    req = '0;
    data_in = '0;
    do_reset();
    chk("rst_grant", 32'(grant), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    req = 8'h01;
    cyc();
    chk("t1_grant", 32'(grant), 32'h01);
    chk("t1_sel", 32'(sel), 32'd0);
    chk("t1_valid", 32'(valid), 32'd1);
    req = 8'h00;
    cyc();
    chk("t1_idle_valid", 32'(valid), 32'd0);
    chk("t1_idle_grant", 32'(grant), 32'h00);
    do_reset();
    req = 8'hFF;
    cyc();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t2_sel%0d", k), 32'(sel), 32'(k % 8));
      chk($sformatf("t2_valid%0d", k), 32'(valid), 32'd1);
      req = 8'hFF & ~(8'h01 << (k % 8));
      cyc();
    end
    do_reset();
    req = 8'h08;
    cyc();
    chk("t3_first", 32'(grant), 32'h08);
    req = 8'h28;
    for (int k = 0; k < 15; k++) cyc();
    chk("t3_hold16", 32'(grant), 32'h08);
    cyc();
`ifdef ARB_HOLD_LIMIT_EN
    chk("t3_forced", 32'(grant), 32'h20);
    chk("t3_forced_sel", 32'(sel), 32'd5);
`else
    chk("t3_kept", 32'(grant), 32'h08);
    chk("t3_kept_sel", 32'(sel), 32'd3);
`endif
    do_reset();
    data_in = 8'h40;
    req = 8'h40;
    chk("t4_y_pre", 32'(y), 32'd0);
    cyc();
    chk("t4_sel", 32'(sel), 32'd6);
    chk("t4_y_grant", 32'(y), 32'd1);
    data_in = 8'hBF;
    #1;
    chk("t4_y_comb0", 32'(y), 32'd0);
    data_in = 8'h40;
    #1;
    chk("t4_y_comb1", 32'(y), 32'd1);
    req = 8'h00;
    cyc();
    chk("t4_valid_off", 32'(valid), 32'd0);
    chk("t4_y_off", 32'(y), 32'd0);
    do_reset();
    req = 8'h20;
    cyc();
    chk("t5_grant5", 32'(grant), 32'h20);
    rst_n = 1'b0;
    cyc();
    chk("t5_rst_grant", 32'(grant), 32'h00);
    chk("t5_rst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    req = 8'h21;
    cyc();
    chk("t5_from0", 32'(sel), 32'd0);
    for (int k = 0; k < 200; k++) begin
      req = 8'($urandom);
      cyc();
      chk("t6_onehot", 32'($onehot0(grant)), 32'd1);
      chk("t6_valid", 32'(valid), 32'(|grant));
      chk("t6_gsel", 32'(grant[sel]), 32'(valid));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
